// File: rtl/eth_pkg.sv
// eth_pkg: shared GMII framing constants, trailer status layout and receive FSM states
package eth_pkg;
  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;
  localparam int STS_CRC_OK  = 0;
  localparam int STS_PHY_ERR = 1;
  localparam int STS_OVF     = 2;
  localparam int STS_RUNT    = 3;
  localparam int STS_LONG    = 4;
  localparam logic [7:0] STS_GOOD = 8'(1 << STS_CRC_OK);
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DISCARD, S_TRAILER} rx_state_e;
endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: next reflected CRC-32 state after absorbing one byte, LSB first
module eth_crc32_d8 import eth_pkg::*; (
  input  logic [31:0] crc_i,
  input  logic [7:0]  d_i,
  output logic [31:0] crc_o
);
  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++) crc_o = (crc_o >> 1) ^ ((crc_o[0] ^ d_i[i]) ? CRC_POLY : 32'h0);
  end
endmodule

// File: rtl/eth_rx_framer.sv
// eth_rx_framer: GMII receive framer that strips preamble/FCS, checks CRC-32 and writes payload plus a status trailer
module eth_rx_framer import eth_pkg::*; #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] eth_rx_d_in,
  input  logic       eth_rx_dv_in,
  input  logic       eth_rx_err_in,
  output logic       wr_en_out,
  output logic [8:0] wr_d_out,
  input  logic       wr_full_in,
  output logic       frame_ok_out,
  output logic       frame_bad_out
);
  logic [7:0]  d_q;
  logic        dv_q, err_q;
  rx_state_e   st_q, st_d;
  logic [31:0] crc_q, crc_d, crc_nxt;
  logic [10:0] len_q, len_d, len_inc;
  logic [31:0] dl_q, dl_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        perr_q, perr_d, ovf_q, ovf_d, long_q, long_d;
  logic        drop_q, drop_d, dpulse_q, dpulse_d;
  logic        out_v_q, out_v_d;
  logic [8:0]  out_q, out_d;
  logic [7:0]  sts;
  logic        lost, wr_ok, ovf_now, long_now, runt, crc_ok, good;

  eth_crc32_d8 u_crc (.crc_i(crc_q), .d_i(d_q), .crc_o(crc_nxt));

  assign wr_ok    = out_v_q & ~wr_full_in;
  assign lost     = out_v_q & ~out_q[8] & wr_full_in;
  assign ovf_now  = ovf_q | lost;
  assign len_inc  = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
  assign long_now = long_q | (int'({21'd0, len_inc}) > MAX_LEN);
  assign runt     = int'({21'd0, len_q}) < MIN_LEN;
  assign crc_ok   = crc_q == CRC_RESIDUE;
  assign good     = out_q[7:0] == STS_GOOD;

  assign wr_en_out     = wr_ok;
  assign wr_d_out      = out_q;
  assign frame_ok_out  = wr_ok & out_q[8] & good;
  assign frame_bad_out = (wr_ok & out_q[8] & ~good) | dpulse_q;

  always_comb begin
    sts              = '0;
    sts[STS_CRC_OK]  = crc_ok;
    sts[STS_PHY_ERR] = perr_q;
    sts[STS_OVF]     = ovf_now;
    sts[STS_RUNT]    = runt;
    sts[STS_LONG]    = long_q;
  end

  always_comb begin
    st_d     = st_q;
    crc_d    = crc_q;
    len_d    = len_q;
    dl_d     = dl_q;
    cnt_d    = cnt_q;
    perr_d   = perr_q;
    ovf_d    = ovf_now;
    long_d   = long_q;
    drop_d   = drop_q;
    dpulse_d = 1'b0;
    out_v_d  = 1'b0;
    out_d    = out_q;
    case (st_q)
      S_IDLE:
        if (dv_q) st_d = (d_q == ETH_PREAMBLE) ? S_PREAMBLE : (d_q == ETH_SFD) ? S_DATA : S_DISCARD;
      S_PREAMBLE:
        st_d = !dv_q ? S_IDLE : (d_q == ETH_PREAMBLE) ? S_PREAMBLE : (d_q == ETH_SFD) ? S_DATA : S_DISCARD;
      S_DATA:
        if (dv_q) begin
          crc_d  = crc_nxt;
          len_d  = len_inc;
          dl_d   = {dl_q[23:0], d_q};
          cnt_d  = (cnt_q == 3'd4) ? cnt_q : cnt_q + 3'd1;
          perr_d = perr_q | err_q;
          long_d = long_now;
          // once a byte is lost the rest of the frame is withheld so the FIFO never sees a gap
          if (cnt_q == 3'd4 && !long_now && !ovf_now) begin
            out_v_d = 1'b1;
            out_d   = {1'b0, dl_q[31:24]};
          end
        end else begin
          out_v_d = 1'b1;
          out_d   = {1'b1, sts};
          drop_d  = 1'b0;
          st_d    = S_TRAILER;
        end
      S_TRAILER: begin
        out_v_d = out_v_q & wr_full_in;
        drop_d  = drop_q | dv_q;
        if (!wr_full_in) begin
          st_d     = (drop_q | dv_q) ? S_DISCARD : S_IDLE;
          dpulse_d = drop_q | dv_q;
        end
      end
      S_DISCARD:
        if (!dv_q) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    if (st_d == S_DATA && st_q != S_DATA) begin
      crc_d  = CRC_INIT;
      len_d  = '0;
      cnt_d  = '0;
      perr_d = 1'b0;
      ovf_d  = 1'b0;
      long_d = 1'b0;
    end
  end

  // dv resets high so a frame still in flight at reset release is discarded until dv drops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_q      <= '0;
      dv_q     <= 1'b1;
      err_q    <= 1'b0;
      st_q     <= S_IDLE;
      crc_q    <= CRC_INIT;
      len_q    <= '0;
      dl_q     <= '0;
      cnt_q    <= '0;
      perr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      long_q   <= 1'b0;
      drop_q   <= 1'b0;
      dpulse_q <= 1'b0;
      out_v_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      d_q      <= eth_rx_d_in;
      dv_q     <= eth_rx_dv_in;
      err_q    <= eth_rx_err_in;
      st_q     <= st_d;
      crc_q    <= crc_d;
      len_q    <= len_d;
      dl_q     <= dl_d;
      cnt_q    <= cnt_d;
      perr_q   <= perr_d;
      ovf_q    <= ovf_d;
      long_q   <= long_d;
      drop_q   <= drop_d;
      dpulse_q <= dpulse_d;
      out_v_q  <= out_v_d;
      out_q    <= out_d;
    end
endmodule

// File: tb/tb_eth_rx_framer.sv
// tb_eth_rx_framer: random-payload directed frames checked against a queue-based framing model
module tb_eth_rx_framer;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_d = '0;
  logic rx_dv = 1'b0, rx_err = 1'b0, full = 1'b0;
  logic wr_en, ok, bad;
  logic [8:0] wr_d;
  int vectors = 0, errs = 0;
  int ok_cnt = 0, bad_cnt = 0, viol = 0, stray = 0, ok0 = 0, bad0 = 0, exp_okd = 0, exp_badd = 0;
  logic [7:0] fr_q[$], pre_q[$];
  logic [8:0] got_q[$], exp_q[$];
  logic [31:0] tab[256];

  eth_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .eth_rx_d_in(rx_d), .eth_rx_dv_in(rx_dv), .eth_rx_err_in(rx_err),
    .wr_en_out(wr_en), .wr_d_out(wr_d), .wr_full_in(full), .frame_ok_out(ok), .frame_bad_out(bad)
  );

  always #4 clk = ~clk;

  always @(negedge clk)
    if (rst_n) begin
      if (wr_en) got_q.push_back(wr_d);
      if (wr_en && full) viol++;
      if (ok) ok_cnt++;
      if (bad) bad_cnt++;
      if ((ok || bad) && !(wr_en && wr_d[8])) stray++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic make(input int nd);
    logic [31:0] c;
    fr_q.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < nd; i++) begin
      fr_q.push_back(8'($urandom));
      c = (c >> 8) ^ tab[c[7:0] ^ fr_q[i]];
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fr_q.push_back(c[8*i +: 8]);
  endtask

  task automatic model(input int lost_at, input bit perr);
    int n, cnt;
    bit ovf, crc_good;
    logic [31:0] c, fcs;
    logic [7:0] st;
    exp_q.delete();
    n = fr_q.size();
    cnt = (n > MAX_LEN) ? MAX_LEN - 4 : n - 4;
    ovf = lost_at >= 0 && lost_at < cnt;
    if (ovf) cnt = lost_at;
    for (int i = 0; i < cnt; i++) exp_q.push_back({1'b0, fr_q[i]});
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n - 4; i++) c = (c >> 8) ^ tab[c[7:0] ^ fr_q[i]];
    fcs = {fr_q[n-1], fr_q[n-2], fr_q[n-3], fr_q[n-4]};
    crc_good = (~c) == fcs;
    st = {3'b000, n > MAX_LEN, n < MIN_LEN, ovf, perr, crc_good};
    exp_q.push_back({1'b1, st});
    exp_okd  = (st == 8'h01) ? 1 : 0;
    exp_badd = 1 - exp_okd;
  endtask

  task automatic drive(input int err_at, input int full_at, input int hold, input int rst_at);
    foreach (pre_q[j]) begin
      @(posedge clk); #1;
      rx_d = pre_q[j]; rx_dv = 1'b1; rx_err = 1'b0; full = 1'b0;
    end
    for (int k = 0; k < fr_q.size(); k++) begin
      @(posedge clk); #1;
      rx_d = fr_q[k]; rx_dv = 1'b1; rx_err = (k == err_at);
      full = full_at >= 0 && k >= full_at + 6;
      if (k == rst_at) rst_n = 1'b0;
      if (k == rst_at + 2) rst_n = 1'b1;
    end
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      rx_d = '0; rx_dv = 1'b0; rx_err = 1'b0;
      if (k >= hold) full = 1'b0;
    end
  endtask

  task automatic check(input string tag);
    int m;
    chk({tag, " entry count"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s entry %0d", tag, i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    chk({tag, " ok pulses"}, ok_cnt - ok0, exp_okd);
    chk({tag, " bad pulses"}, bad_cnt - bad0, exp_badd);
    chk({tag, " write while full"}, viol, 0);
    chk({tag, " stray pulse"}, stray, 0);
    got_q.delete();
    ok0 = ok_cnt;
    bad0 = bad_cnt;
  endtask

  initial begin
    int idx;
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = n;
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB8_8320 : c >> 1;
      tab[n] = c;
    end
    repeat (3) @(negedge clk);
    chk("reset wr_en", {31'd0, wr_en}, 0);
    chk("reset wr_d", {23'd0, wr_d}, 0);
    chk("reset frame_ok", {31'd0, ok}, 0);
    chk("reset frame_bad", {31'd0, bad}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    pre_q = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
    make(60); model(-1, 1'b0); drive(-1, -1, 0, -1); check("good");

    idx = $urandom_range(0, 59);
    fr_q[idx] = fr_q[idx] ^ 8'(1 << $urandom_range(0, 7));
    model(-1, 1'b0); drive(-1, -1, 0, -1); check("crc error");

    pre_q = '{8'hD5};
    make(20); model(-1, 1'b0); drive(-1, -1, 0, -1); check("runt");

    pre_q = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
    make(60); model(-1, 1'b1); drive(10, -1, 0, -1); check("phy err");

    pre_q = '{8'h55, 8'h55, 8'h55, 8'h57, 8'h55, 8'h55, 8'h55, 8'hD5};
    make(60); exp_q.delete(); exp_okd = 0; exp_badd = 0; drive(-1, -1, 0, -1); check("bad preamble");

    pre_q = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
    make(96); model(30, 1'b0); drive(-1, 30, 4, -1); check("fifo full");

    make(596);
    drive(-1, -1, 0, 500);
    exp_q.delete();
    for (int i = 0; i < 494; i++) exp_q.push_back({1'b0, fr_q[i]});
    exp_okd = 0; exp_badd = 0;
    check("reset mid-frame");

    make($urandom_range(60, 200)); model(-1, 1'b0); drive(-1, -1, 0, -1); check("after reset");

    make(1596); model(-1, 1'b0); drive(-1, -1, 0, -1); check("oversize");

    for (int r = 0; r < 4; r++) begin
      int e;
      e = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 9) : -1;
      make($urandom_range(10, 300)); model(-1, e >= 0); drive(e, -1, 0, -1);
      check($sformatf("random %0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
